ssd_scanner: RTL and testbench

- Multiplexed seven-segment display driver for the board's 8-digit common-anode display.
- Accepts a 32-bit hex value from the processor side over a valid/ready write port and holds it in a shadow register.
- Commits the shadow value to the visible register only at a frame boundary, so a frame never shows a mix of old and new digits.
- Scans the digits with an internal refresh prescaler and drives registered anode and cathode lines.

---
 rtl/ssd_scanner.sv | 154 +++++++++++++++
 tb/tb_ssd_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scanner.sv
// ssd_scanner: multiplexed seven-segment driver for a common-anode display.
// A processor value is accepted into a shadow register over a valid/ready
// port. It becomes visible only at a frame boundary, so a frame never shows
// a mix of old and new digits.
`timescale 1ns/1ps

module ssd_scanner #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned REFRESH_DIV = 131072
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_data,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        cathode,
    output logic              dp,
    output logic              frame_tick
);

    localparam int unsigned PS_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PS_W-1:0]   prescaler;
    logic [IDX_W-1:0]  digit_idx;
    logic [31:0]       shadow;
    logic [31:0]       display;
    logic              pending;

    logic              step;
    logic              boundary;
    logic              xfer;

    logic [DIGITS-1:0] upper_zero;
    logic              zero_run;
    logic [31:0]       nib_shift;
    logic [3:0]        cur_nib;
    logic              blank_cur;

    logic [DIGITS-1:0] anode_nxt;
    logic [6:0]        cathode_nxt;
    logic              dp_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign step     = (prescaler == PS_LAST);
    assign boundary = step && (digit_idx == IDX_LAST);
    assign wr_ready = ~pending;
    assign xfer     = wr_valid && wr_ready;

    // Refresh prescaler and digit scan counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (step) begin
            prescaler <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Shadow capture on handshake; commit to the visible value at a frame boundary.
    // A transfer can only happen while nothing is pending, so a transfer
    // and a commit never compete in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else if (xfer) begin
            shadow  <= wr_data;
            pending <= 1'b1;
        end else if (boundary && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end
    end

    // One-cycle pulse following each frame boundary edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
        end
    end

    // Per-digit flag: this nibble and every more-significant nibble are zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run && (display[4*(DIGITS-1-k) +: 4] == 4'h0);
            upper_zero[DIGITS-1-k] = zero_run;
        end
    end

    // Decode the current digit into next anode/cathode/dp values.
    always_comb begin
        nib_shift   = display >> {digit_idx, 2'b00};
        cur_nib     = nib_shift[3:0];
        blank_cur   = blank_lz && (digit_idx != '0) && upper_zero[digit_idx];
        anode_nxt   = '1;
        cathode_nxt = 7'h7F;
        dp_nxt      = 1'b1;
        if (!blank_cur) begin
            anode_nxt   = ~(DIGITS'(1) << digit_idx);
            cathode_nxt = hex_to_seg(cur_nib);
            dp_nxt      = ~dp_mask[digit_idx];
        end
    end

    // Registered display drive lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode   <= '1;
            cathode <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            anode   <= anode_nxt;
            cathode <= cathode_nxt;
            dp      <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scanner.sv
// Testbench for ssd_scanner: directed vector table, corner-case sequences
// and randomized traffic checked against a cycle-count based reference model.
`timescale 1ns/1ps

module tb_ssd_scanner;

    localparam int unsigned DIG   = 8;
    localparam int unsigned RD    = 4;
    localparam int unsigned FRAME = DIG * RD;

    logic           clk;
    logic           rst;
    logic           wr_valid;
    logic           wr_ready;
    logic [31:0]    wr_data;
    logic           blank_lz;
    logic [DIG-1:0] dp_mask;
    logic [DIG-1:0] anode;
    logic [6:0]     cathode;
    logic           dp;
    logic           frame_tick;

    ssd_scanner #(
        .DIGITS      (DIG),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .anode      (anode),
        .cathode    (cathode),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: position in the scan is derived from the number of
    // clock edges since reset; value flow is shadow/pending/display.
    logic [6:0]  seg_tab [16];
    int unsigned m_e;
    logic [31:0] m_disp;
    logic [31:0] m_shadow;
    logic        m_pending;
    logic [7:0]  m_anode;
    logic [6:0]  m_cath;
    logic        m_dp;
    logic        m_tick;
    logic        m_last_xfer;

    typedef struct {
        logic [31:0]     data;
        logic            blz;
        logic [7:0]      dpm;
        logic [7:0][6:0] cath;     // expected cathode, indexed by digit
        logic [7:0]      blanked;  // 1 = digit expected dark
        logic [7:0]      dp_on;    // 1 = decimal point lit
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_e         = 0;
        m_disp      = '0;
        m_shadow    = '0;
        m_pending   = 1'b0;
        m_anode     = 8'hFF;
        m_cath      = 7'h7F;
        m_dp        = 1'b1;
        m_tick      = 1'b0;
        m_last_xfer = 1'b0;
    endtask

    task automatic model_edge();
        int unsigned pres;
        int unsigned idx;
        logic        bnd;
        logic        xf;
        pres = m_e % RD;
        idx  = (m_e / RD) % DIG;
        bnd  = (pres == RD - 1) && (idx == DIG - 1);
        xf   = wr_valid && !m_pending;
        if (idx != 0 && blank_lz && ((m_disp >> (4 * idx)) == 32'd0)) begin
            m_anode = 8'hFF;
            m_cath  = 7'h7F;
            m_dp    = 1'b1;
        end else begin
            m_anode = ~(8'h01 << idx);
            m_cath  = seg_tab[(m_disp >> (4 * idx)) & 32'hF];
            m_dp    = !dp_mask[idx];
        end
        m_tick = bnd;
        if (xf) begin
            m_shadow  = wr_data;
            m_pending = 1'b1;
        end else if (bnd && m_pending) begin
            m_disp    = m_shadow;
            m_pending = 1'b0;
        end
        m_last_xfer = xf;
        m_e++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", {14'd0, anode, cathode, dp, frame_tick, wr_ready},
              {14'd0, m_anode, m_cath, m_dp, m_tick, ~m_pending});
    endtask

    // Must be entered at a negedge; asserts reset between edges.
    task automatic apply_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_anode", {24'd0, anode}, 32'hFF);
        check("rst_cathode", {25'd0, cathode}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 200);
        check(name, {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        logic [7:0] exp_an;
        blank_lz = v.blz;
        dp_mask  = v.dpm;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        wr_data  = v.data;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("vec_ready_drop", {31'd0, wr_ready}, 32'd0);
        wait_frame("vec_commit");
        check("vec_ready_back", {31'd0, wr_ready}, 32'd1);
        for (int k = 1; k <= int'(FRAME); k++) begin
            tick();
            if (k % 4 == 2) begin
                int d;
                d = (k - 1) / 4;
                exp_an = v.blanked[d] ? 8'hFF : ~(8'h01 << d);
                check("vec_anode", {24'd0, anode}, {24'd0, exp_an});
                check("vec_cathode", {25'd0, cathode}, {25'd0, v.cath[d]});
                check("vec_dp", {31'd0, dp}, {31'd0, ~v.dp_on[d]});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vecs[0] = '{data: 32'h0123_4567, blz: 1'b0, dpm: 8'h00,
                    cath: {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78},
                    blanked: 8'h00, dp_on: 8'h00};
        vecs[1] = '{data: 32'h0000_00A5, blz: 1'b1, dpm: 8'h00,
                    cath: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12},
                    blanked: 8'hFC, dp_on: 8'h00};
        vecs[2] = '{data: 32'h0000_00A5, blz: 1'b0, dpm: 8'h04,
                    cath: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12},
                    blanked: 8'h00, dp_on: 8'h04};
        vecs[3] = '{data: 32'h89AB_CDEF, blz: 1'b1, dpm: 8'h04,
                    cath: {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    blanked: 8'h00, dp_on: 8'h04};
        vecs[4] = '{data: 32'h0000_0000, blz: 1'b1, dpm: 8'h01,
                    cath: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                    blanked: 8'hFE, dp_on: 8'h01};
        vecs[5] = '{data: 32'h00F0_0000, blz: 1'b1, dpm: 8'hFF,
                    cath: {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                    blanked: 8'hC0, dp_on: 8'h3F};

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        blank_lz = 1'b0;
        dp_mask  = '0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Idle scan: frame_tick every FRAME cycles from reset release.
        for (int f = 0; f < 2; f++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!frame_tick && n < 200);
            check("idle_frame_len", n, FRAME);
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Held value offered while pending is accepted only after the boundary.
        wait_frame("held_align");
        repeat (5) tick();
        wr_data  = 32'h1111_1111;
        wr_valid = 1'b1;
        tick();
        wr_data  = 32'h2222_2222;
        repeat (3) begin
            tick();
            check("held_not_ready", {31'd0, wr_ready}, 32'd0);
        end
        wait_frame("held_commit1");
        check("held_ready_back", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        check("held_taken", {31'd0, wr_ready}, 32'd0);
        check("held_first_shown", {25'd0, cathode}, 32'h79);
        wait_frame("held_commit2");
        tick();
        check("held_second_shown", {25'd0, cathode}, 32'h24);

        // Transfer on the exact boundary edge commits one frame later.
        while ((m_e % FRAME) != FRAME - 1) tick();
        wr_data  = 32'h0000_0009;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("bnd_tick", {31'd0, frame_tick}, 32'd1);
        check("bnd_captured", {31'd0, wr_ready}, 32'd0);
        tick();
        check("bnd_not_committed", {25'd0, cathode}, 32'h24);
        wait_frame("bnd_commit");
        tick();
        check("bnd_committed_next", {25'd0, cathode}, 32'h10);

        // Reset mid-frame discards a pending value.
        wr_data  = 32'hFFFF_FFFF;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("rst_pending_set", {31'd0, wr_ready}, 32'd0);
        repeat (3) tick();
        apply_reset();
        repeat (34) tick();
        check("rst_pending_discarded", {25'd0, cathode}, 32'h40);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (wr_valid && m_last_xfer) wr_valid = 1'b0;
            if (!wr_valid && $urandom_range(0, 9) == 0) begin
                wr_valid = 1'b1;
                wr_data  = $urandom >> $urandom_range(0, 31);
            end
            if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) dp_mask = 8'($urandom);
            if (i == 700) apply_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
